// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle arithmetic shifter with valid/ready handshakes.
// Performs one 1-bit arithmetic shift per enabled cycle (ASR or ASL). ASL tracks
// signed overflow as a sticky flag for the whole operation.
//
// Optional feature: define SHIFT_ROTATE_EN to add in_rot, which turns each step
// into a rotate in the in_rl direction (overflow stays 0).
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   ce         clock enable for shift steps only
//   in_valid   request valid
//   in_ready   request accepted (IDLE only)
//   in_data    operand
//   in_amt     shift amount, 0..WIDTH-1
//   in_rl      1 = arithmetic right, 0 = arithmetic left
//   in_rot     (SHIFT_ROTATE_EN only) 1 = rotate instead of shift
//   out_valid  result valid (HOLD)
//   out_ready  consumer accepts result
//   out_data   result, 0 when out_valid=0
//   out_ovf    ASL signed overflow, 0 when out_valid=0
//   busy       operation in flight (SHIFT or HOLD)
module shift_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNTW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [CNTW-1:0]  in_amt,
   input  logic             in_rl,
`ifdef SHIFT_ROTATE_EN
   input  logic             in_rot,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             rl_q, rl_d;
   logic             ovf_q, ovf_d;
`ifdef SHIFT_ROTATE_EN
   logic             rot_q, rot_d;
`endif

   logic [WIDTH-1:0] ash_data, step_data;
   logic             ash_ovf, step_ovf;

   // One-bit step of the held operand
   always_comb begin
      ash_data = rl_q ? {data_q[WIDTH-1], data_q[WIDTH-1:1]} : {data_q[WIDTH-2:0], 1'b0};
      // Left step overflows when the two top bits differ before the shift
      ash_ovf  = ~rl_q & (data_q[WIDTH-1] ^ data_q[WIDTH-2]);
`ifdef SHIFT_ROTATE_EN
      if (rot_q) begin
         step_data = rl_q ? {data_q[0], data_q[WIDTH-1:1]} : {data_q[WIDTH-2:0], data_q[WIDTH-1]};
         step_ovf  = 1'b0;
      end else begin
         step_data = ash_data;
         step_ovf  = ash_ovf;
      end
`else
      step_data = ash_data;
      step_ovf  = ash_ovf;
`endif
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      rl_d    = rl_q;
      ovf_d   = ovf_q;
`ifdef SHIFT_ROTATE_EN
      rot_d   = rot_q;
`endif
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               data_d  = in_data;
               cnt_d   = in_amt;
               rl_d    = in_rl;
               ovf_d   = 1'b0;
`ifdef SHIFT_ROTATE_EN
               rot_d   = in_rot;
`endif
               state_d = (in_amt != '0) ? StShift : StHold;
            end
         end
         StShift: begin
            if (ce) begin
               data_d = step_data;
               ovf_d  = ovf_q | step_ovf;
               cnt_d  = cnt_q - CNTW'(1);
               if (cnt_q == CNTW'(1)) state_d = StHold;
            end
         end
         StHold: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         data_q  <= '0;
         cnt_q   <= '0;
         rl_q    <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef SHIFT_ROTATE_EN
         rot_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         rl_q    <= rl_d;
         ovf_q   <= ovf_d;
`ifdef SHIFT_ROTATE_EN
         rot_q   <= rot_d;
`endif
      end
   end

   // in_ready is gated by rst so it reads 0 for the whole reset window
   always_comb begin
      in_ready  = (state_q == StIdle) & ~rst;
      out_valid = (state_q == StHold);
      out_data  = out_valid ? data_q : '0;
      out_ovf   = out_valid & ovf_q;
      busy      = (state_q == StShift) | (state_q == StHold);
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Testbench for shift_seq_ctrl (WIDTH=8). Reference model computes each result
// directly from the operand with shift operators and tracks only how many
// enabled cycles remain; a negedge process compares every cycle.
// Define SHIFT_ROTATE_EN to also exercise the rotate option.
module tb_shift_seq_ctrl;

   localparam int W  = 8;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ce = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_rl = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic [CW-1:0] in_amt = '0;
`ifdef SHIFT_ROTATE_EN
   logic          in_rot = 1'b0;
`endif
   logic          in_ready, out_valid, out_ovf, busy;
   logic [W-1:0]  out_data;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   shift_seq_ctrl #(.WIDTH(W), .CNTW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_rl     (in_rl),
`ifdef SHIFT_ROTATE_EN
      .in_rot    (in_rot),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Result of the whole operation in one go: {ovf, data}
   function automatic logic [W:0] ref_result(input logic [W-1:0] d, input int amt,
                                             input logic rl, input logic rot);
      logic [2*W-1:0]      dd;
      logic [2*W-1:0]      sh;
      logic [W-1:0]        res;
      logic signed [W-1:0] sres, sd;
      logic                ovf;
      dd  = {d, d};
      ovf = 1'b0;
      if (rot) begin
         if (rl) begin
            sh  = dd >> amt;
            res = sh[W-1:0];
         end else begin
            sh  = dd << amt;
            res = sh[2*W-1:W];
         end
      end else if (rl) begin
         sd  = d;
         res = sd >>> amt;
      end else begin
         res  = d << amt;
         sres = res;
         sd   = d;
         // Overflow iff the value does not survive a round trip
         ovf  = ((sres >>> amt) != sd);
      end
      return {ovf, res};
   endfunction

   // Model: 0 = idle, 1 = shifting, 2 = result held
   int           m_phase = 0;
   int           m_rem = 0;
   logic [W-1:0] m_res = '0;
   logic         m_ovf = 1'b0;
   logic         m_rot;

`ifdef SHIFT_ROTATE_EN
   assign m_rot = in_rot;
`else
   assign m_rot = 1'b0;
`endif

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0;
         m_rem   = 0;
         m_res   = '0;
         m_ovf   = 1'b0;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
               {m_ovf, m_res} = ref_result(in_data, int'(in_amt), in_rl, m_rot);
               m_rem   = int'(in_amt);
               m_phase = (m_rem == 0) ? 2 : 1;
            end
            1: if (ce) begin
               m_rem--;
               if (m_rem == 0) m_phase = 2;
            end
            default: if (out_ready) m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("in_ready", in_ready, (m_phase == 0) && !rst);
      chk("out_valid", out_valid, m_phase == 2);
      chk("busy", busy, m_phase != 0);
      chk("out_data", out_data, (m_phase == 2) ? m_res : '0);
      chk("out_ovf", out_ovf, (m_phase == 2) ? m_ovf : 1'b0);
   end

   // One request with literal expectations; ce low for cycles [st, st+len),
   // out_ready held low for hold extra cycles once the result appears.
   task automatic run_op(input string nm, input logic [W-1:0] d, input int amt, input logic rl,
                         input int st, input int len, input int hold,
                         input logic [W-1:0] exp_d, input logic exp_ovf, input int exp_lat);
      int lat;
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk({nm, " ready"}, in_ready, 1'b1);
      in_valid  = 1'b1;
      in_data   = d;
      in_amt    = amt[CW-1:0];
      in_rl     = rl;
      ce        = 1'b1;
      out_ready = (hold == 0);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         lat++;
         ce = !(lat >= st && lat < st + len);
      end while (!out_valid && lat < 64);
      ce = 1'b1;
      chk({nm, " latency"}, lat, exp_lat);
      chk({nm, " data"}, out_data, exp_d);
      chk({nm, " ovf"}, out_ovf, exp_ovf);
      chk({nm, " in_ready hold"}, in_ready, 1'b0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk({nm, " stable valid"}, out_valid, 1'b1);
         chk({nm, " stable data"}, out_data, exp_d);
         chk({nm, " stable ready"}, in_ready, 1'b0);
      end
      // A request offered while HOLD completes must not be taken
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hFF;
      in_amt    = 3'd5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk({nm, " no accept on completion"}, busy, 1'b0);
      chk({nm, " ready after"}, in_ready, 1'b1);
      out_ready = 1'b0;
   endtask

   initial begin
      #2;
      chk("reset out_valid", out_valid, 1'b0);
      chk("reset busy", busy, 1'b0);
      chk("reset in_ready", in_ready, 1'b0);
      chk("reset out_data", out_data, 8'h00);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1 chk("ready after reset", in_ready, 1'b1);

      run_op("asr 96>>3", 8'h96, 3, 1'b1, 0, 0, 0, 8'hF2, 1'b0, 4);
      run_op("asl 35<<2", 8'h35, 2, 1'b0, 0, 0, 0, 8'hD4, 1'b1, 3);
      run_op("amt0 5A", 8'h5A, 0, 1'b0, 0, 0, 0, 8'h5A, 1'b0, 1);
      run_op("asl 13<<2", 8'h13, 2, 1'b0, 0, 0, 0, 8'h4C, 1'b0, 3);
      run_op("stall 80>>2", 8'h80, 2, 1'b1, 2, 3, 5, 8'hE0, 1'b0, 6);

      // Reset in the middle of a long shift
      in_valid = 1'b1; in_data = 8'h96; in_amt = 3'd7; in_rl = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("mid shift busy", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("async rst busy", busy, 1'b0);
      chk("async rst valid", out_valid, 1'b0);
      chk("async rst ready", in_ready, 1'b0);
      chk("async rst data", out_data, 8'h00);
      @(posedge clk);
      #1 rst = 1'b0;
      #1 chk("ready after mid reset", in_ready, 1'b1);
      run_op("after reset", 8'h96, 3, 1'b1, 0, 0, 0, 8'hF2, 1'b0, 4);

`ifdef SHIFT_ROTATE_EN
      in_rot = 1'b1;
      run_op("ror 81>>1", 8'h81, 1, 1'b1, 0, 0, 0, 8'hC0, 1'b0, 2);
      run_op("rol 81<<3", 8'h81, 3, 1'b0, 0, 0, 0, 8'h0C, 1'b0, 4);
      in_rot = 1'b0;
`endif

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         ce        = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 1) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = W'($urandom);
         in_amt    = CW'($urandom_range(0, W - 1));
         in_rl     = ($urandom_range(0, 1) != 0);
`ifdef SHIFT_ROTATE_EN
         in_rot    = ($urandom_range(0, 2) == 0);
`endif
         rst       = ($urandom_range(0, 499) == 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1);
   end

endmodule
